qc_ldpc_codeword_emitter: RTL and testbench

Downstream stage of the QC-LDPC encoder. Forwards the NUM_INFO_BLKS systematic info blocks of a codeword as they stream in, then appends the NUM_PAR_BLK parity blocks that the encoder delivers in one parallel word. The result is a single valid/ready stream of TOTAL_BLKS blocks per codeword, each MAX_Z bits wide, with bits at and above the active Z forced to zero. It owns codeword framing (block index, last flag) and protocol error flags.

---
 rtl/qc_ldpc_pkg.sv | 46 ++++
 rtl/qc_ldpc_codeword_emitter_if.sv | 32 +++
 rtl/qc_ldpc_par_buf.sv | 52 +++++
 rtl/qc_ldpc_codeword_emitter.sv | 143 ++++++++++++++
 tb/tb_qc_ldpc_codeword_emitter.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qc_ldpc_pkg.sv
// Shared QC-LDPC encoder definitions: geometry, lifting sizes, emitter states and Z helpers.
package qc_ldpc_pkg;

    localparam int unsigned NUM_Z         = 3;
    localparam int unsigned MAX_Z         = 81;
    localparam int unsigned NUM_INFO_BLKS = 20;
    localparam int unsigned NUM_PAR_BLK   = 4;
    localparam int unsigned TOTAL_BLKS    = NUM_INFO_BLKS + NUM_PAR_BLK;
    localparam int unsigned IDX_W         = $clog2(TOTAL_BLKS);
    localparam int unsigned Z_W           = $clog2(MAX_Z + 1);
    localparam int unsigned K_W           = $clog2(NUM_PAR_BLK);
    localparam int unsigned PAR_W         = NUM_PAR_BLK * MAX_Z;

    // Element i is the lifting size selected by z_sel bit i.
    localparam logic [NUM_Z-1:0][Z_W-1:0] Z_VALUES = {Z_W'(81), Z_W'(54), Z_W'(27)};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INFO,
        ST_WAIT_PAR,
        ST_PAR
    } emitter_state_e;

    // Ones in bit positions below z.
    function automatic logic [MAX_Z-1:0] zmask(input logic [Z_W-1:0] z);
        logic [MAX_Z-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_Z; i++) begin
            m[i] = (Z_W'(i) < z);
        end
        return m;
    endfunction

    // A select that is not one-hot falls back to the widest lane.
    function automatic logic [Z_W-1:0] onehot_to_z(input logic [NUM_Z-1:0] z_sel);
        logic [Z_W-1:0] z;
        z = Z_W'(MAX_Z);
        if ($onehot(z_sel)) begin
            for (int unsigned i = 0; i < NUM_Z; i++) begin
                if (z_sel[i]) z = Z_VALUES[i];
            end
        end
        return z;
    endfunction

endpackage

// File: rtl/qc_ldpc_codeword_emitter_if.sv
// Info/parity input streams, codeword output stream and error flags of the emitter.
interface qc_ldpc_codeword_emitter_if;
    import qc_ldpc_pkg::*;

    logic [NUM_Z-1:0] z_sel;
    logic             info_valid;
    logic             info_ready;
    logic [MAX_Z-1:0] info_data;
    logic             par_valid;
    logic [PAR_W-1:0] par_data;
    logic             cw_valid;
    logic             cw_ready;
    logic [MAX_Z-1:0] cw_data;
    logic [IDX_W-1:0] cw_blk_idx;
    logic             cw_is_par;
    logic             cw_last;
    logic             err_zsel;
    logic             err_par_ovf;

    modport master (
        output z_sel, info_valid, info_data, par_valid, par_data, cw_ready,
        input  info_ready, cw_valid, cw_data, cw_blk_idx, cw_is_par, cw_last,
               err_zsel, err_par_ovf
    );

    modport slave (
        input  z_sel, info_valid, info_data, par_valid, par_data, cw_ready,
        output info_ready, cw_valid, cw_data, cw_blk_idx, cw_is_par, cw_last,
               err_zsel, err_par_ovf
    );

endinterface

// File: rtl/qc_ldpc_par_buf.sv
// Single-entry parity buffer: capture when empty, sticky overflow when full, per-block read mux.
module qc_ldpc_par_buf
    import qc_ldpc_pkg::*;
(
    input  logic             CLK,
    input  logic             rst,
    input  logic             par_valid_i,
    input  logic [PAR_W-1:0] par_data_i,
    input  logic             free_i,
    input  logic [K_W-1:0]   rd_k_i,
    output logic             full_o,
    output logic             ovf_o,
    output logic [MAX_Z-1:0] rd_data_c
);

    logic [NUM_PAR_BLK-1:0][MAX_Z-1:0] data_q, data_d;
    logic                              full_q, full_d;
    logic                              ovf_q, ovf_d;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            full_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
            ovf_q  <= ovf_d;
        end
    end

    // Freeing is applied first so a strobe in the free cycle lands in the emptied buffer.
    always_comb begin
        data_d = data_q;
        full_d = full_q;
        ovf_d  = ovf_q;
        if (free_i) full_d = 1'b0;
        if (par_valid_i) begin
            if (!full_d) begin
                data_d = par_data_i;
                full_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    assign full_o    = full_q;
    assign ovf_o     = ovf_q;
    assign rd_data_c = data_q[rd_k_i];

endmodule

// File: rtl/qc_ldpc_codeword_emitter.sv
// Frames info beats followed by buffered parity blocks into one masked codeword stream.
module qc_ldpc_codeword_emitter
    import qc_ldpc_pkg::*;
(
    input  logic                       CLK,
    input  logic                       rst,
    qc_ldpc_codeword_emitter_if.slave  bus
);

    emitter_state_e   state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [Z_W-1:0]   z_q, z_d;
    logic             err_zsel_q, err_zsel_d;
    logic             cw_valid_q, cw_valid_d;
    logic [MAX_Z-1:0] cw_data_q, cw_data_d;
    logic [IDX_W-1:0] cw_idx_q, cw_idx_d;
    logic             cw_is_par_q, cw_is_par_d;
    logic             cw_last_q, cw_last_d;

    logic             load_c;
    logic             info_ready_c;
    logic             par_free_c;
    logic             par_full;
    logic             par_ovf;
    logic [MAX_Z-1:0] par_rd_data_c;

    qc_ldpc_par_buf u_par_buf (
        .CLK        (CLK),
        .rst        (rst),
        .par_valid_i(bus.par_valid),
        .par_data_i (bus.par_data),
        .free_i     (par_free_c),
        .rd_k_i     (cnt_q[K_W-1:0]),
        .full_o     (par_full),
        .ovf_o      (par_ovf),
        .rd_data_c  (par_rd_data_c)
    );

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            z_q         <= Z_W'(MAX_Z);
            err_zsel_q  <= 1'b0;
            cw_valid_q  <= 1'b0;
            cw_data_q   <= '0;
            cw_idx_q    <= '0;
            cw_is_par_q <= 1'b0;
            cw_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            z_q         <= z_d;
            err_zsel_q  <= err_zsel_d;
            cw_valid_q  <= cw_valid_d;
            cw_data_q   <= cw_data_d;
            cw_idx_q    <= cw_idx_d;
            cw_is_par_q <= cw_is_par_d;
            cw_last_q   <= cw_last_d;
        end
    end

    // cnt_q is the info block index in INFO and the parity block index in PAR.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        z_d          = z_q;
        err_zsel_d   = err_zsel_q;
        cw_valid_d   = cw_valid_q;
        cw_data_d    = cw_data_q;
        cw_idx_d     = cw_idx_q;
        cw_is_par_d  = cw_is_par_q;
        cw_last_d    = cw_last_q;
        info_ready_c = 1'b0;
        par_free_c   = 1'b0;
        load_c       = !cw_valid_q || bus.cw_ready;
        if (load_c) cw_valid_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                info_ready_c = load_c;
                if (bus.info_valid && load_c) begin
                    z_d = onehot_to_z(bus.z_sel);
                    if (!$onehot(bus.z_sel)) err_zsel_d = 1'b1;
                    cw_valid_d  = 1'b1;
                    cw_data_d   = bus.info_data & zmask(z_d);
                    cw_idx_d    = '0;
                    cw_is_par_d = 1'b0;
                    cw_last_d   = 1'b0;
                    cnt_d       = IDX_W'(1);
                    state_d     = ST_INFO;
                end
            end
            ST_INFO: begin
                info_ready_c = load_c;
                if (bus.info_valid && load_c) begin
                    cw_valid_d  = 1'b1;
                    cw_data_d   = bus.info_data & zmask(z_q);
                    cw_idx_d    = cnt_q;
                    cw_is_par_d = 1'b0;
                    cw_last_d   = 1'b0;
                    if (cnt_q == IDX_W'(NUM_INFO_BLKS - 1)) begin
                        cnt_d   = '0;
                        state_d = par_full ? ST_PAR : ST_WAIT_PAR;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            ST_WAIT_PAR: begin
                if (par_full) state_d = ST_PAR;
            end
            ST_PAR: begin
                if (load_c) begin
                    cw_valid_d  = 1'b1;
                    cw_data_d   = par_rd_data_c & zmask(z_q);
                    cw_idx_d    = IDX_W'(NUM_INFO_BLKS) + cnt_q;
                    cw_is_par_d = 1'b1;
                    cw_last_d   = (cnt_q == IDX_W'(NUM_PAR_BLK - 1));
                    if (cw_last_d) begin
                        par_free_c = 1'b1;
                        cnt_d      = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Ready is the only combinational output; it must stay low throughout reset.
    assign bus.info_ready  = info_ready_c & ~rst;
    assign bus.cw_valid    = cw_valid_q;
    assign bus.cw_data     = cw_data_q;
    assign bus.cw_blk_idx  = cw_idx_q;
    assign bus.cw_is_par   = cw_is_par_q;
    assign bus.cw_last     = cw_last_q;
    assign bus.err_zsel    = err_zsel_q;
    assign bus.err_par_ovf = par_ovf;

endmodule

// File: tb/tb_qc_ldpc_codeword_emitter.sv
// Directed self-checking bench for qc_ldpc_codeword_emitter.
`timescale 1ns/1ps
module tb_qc_ldpc_codeword_emitter;
    import qc_ldpc_pkg::*;

    localparam logic [MAX_Z-1:0] M27  = 81'h7FFFFFF;
    localparam logic [MAX_Z-1:0] M54  = 81'h3FFFFFFFFFFFFF;
    localparam logic [MAX_Z-1:0] M81  = {MAX_Z{1'b1}};
    localparam logic [MAX_Z-1:0] ONES = {MAX_Z{1'b1}};

    typedef struct {
        logic [MAX_Z-1:0] d;
        logic [IDX_W-1:0] idx;
        logic             par;
        logic             last;
        int               cyc;
    } rec_t;

    typedef struct {
        bit               v;
        bit               r;
        logic [MAX_Z-1:0] d;
        logic [IDX_W-1:0] idx;
        int               cyc;
    } snap_t;

    logic CLK = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc [NUM_INFO_BLKS];
    bit   tog_ready = 1'b0;
    bit   abort_cw = 1'b0;
    bit   snap_en = 1'b0;
    rec_t  mon_q [$];
    snap_t snap_q [$];

    qc_ldpc_codeword_emitter_if bus ();

    qc_ldpc_codeword_emitter dut (
        .CLK(CLK),
        .rst(rst),
        .bus(bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Record every transfer (valid && ready) and, when enabled, every cycle's output state.
    always @(negedge CLK) begin
        if (!rst && bus.cw_valid && bus.cw_ready) begin
            rec_t r;
            r.d = bus.cw_data; r.idx = bus.cw_blk_idx; r.par = bus.cw_is_par;
            r.last = bus.cw_last; r.cyc = cyc;
            mon_q.push_back(r);
        end
        if (snap_en && !rst) begin
            snap_t s;
            s.v = bus.cw_valid; s.r = bus.cw_ready; s.d = bus.cw_data;
            s.idx = bus.cw_blk_idx; s.cyc = cyc;
            snap_q.push_back(s);
        end
    end

    function automatic logic [MAX_Z-1:0] beat(input logic [MAX_Z-1:0] base, input bit vary, input int b);
        logic [26:0] w;
        w = 27'(b * 32'h01357A6B + 32'h2468ACE1);
        return vary ? (base ^ {w, ~w, w}) : base;
    endfunction

    function automatic logic [PAR_W-1:0] mk_par(input logic [MAX_Z-1:0] base, input bit vary);
        logic [PAR_W-1:0] p;
        for (int k = 0; k < NUM_PAR_BLK; k++) p[k*MAX_Z +: MAX_Z] = beat(base, vary, 50 + k);
        return p;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
        if (tog_ready) bus.cw_ready = ~bus.cw_ready;
    endtask

    // Drive one codeword of info beats; parity pulses on given beats or p_gap cycles after the last.
    task automatic run_cw(input logic [NUM_Z-1:0] zs, input logic [MAX_Z-1:0] base, input bit vary,
                          input int p1_beat, input int p2_beat, input int p_gap,
                          input logic [PAR_W-1:0] p1, input logic [PAR_W-1:0] p2);
        int   b;
        int   guard;
        bit   s1;
        bit   s2;
        logic acc;
        b = 0; guard = 0; s1 = 0; s2 = 0;
        while (b < NUM_INFO_BLKS && guard < 400 && !abort_cw) begin
            bus.info_valid = 1'b1;
            bus.info_data  = beat(base, vary, b);
            bus.z_sel      = (b == 0) ? zs : 3'b100;
            bus.par_valid  = 1'b0;
            if (b == p1_beat && !s1) begin
                bus.par_valid = 1'b1; bus.par_data = p1; s1 = 1'b1;
            end else if (b == p2_beat && !s2) begin
                bus.par_valid = 1'b1; bus.par_data = p2; s2 = 1'b1;
            end
            @(negedge CLK);
            acc = bus.info_ready;
            if (acc) acc_cyc[b] = cyc;
            tick();
            if (acc) b++;
            guard++;
        end
        bus.info_valid = 1'b0;
        bus.par_valid  = 1'b0;
        if (!abort_cw) begin
            checks++;
            if (b != NUM_INFO_BLKS) begin
                errors++;
                $display("FAIL info_accept: accepted %0d beats, required %0d", b, NUM_INFO_BLKS);
            end
            if (p1_beat < 0) begin
                repeat (p_gap) tick();
                bus.par_valid = 1'b1;
                bus.par_data  = p1;
                tick();
                bus.par_valid = 1'b0;
            end
        end
    endtask

    // Pop one codeword from the monitor and compare framing and masked data.
    task automatic check_cw(input string tag, input logic [MAX_Z-1:0] mask, input logic [MAX_Z-1:0] base,
                            input bit vary, input logic [PAR_W-1:0] par, input bit chk_lat);
        int               guard;
        rec_t             r;
        logic [MAX_Z-1:0] exp_d;
        guard = 0;
        while (mon_q.size() < TOTAL_BLKS && guard < 300) begin
            tick();
            guard++;
        end
        checks++;
        if (mon_q.size() < TOTAL_BLKS) begin
            errors++;
            $display("FAIL %s_count: got %0d blocks, required %0d", tag, mon_q.size(), TOTAL_BLKS);
            return;
        end
        for (int i = 0; i < TOTAL_BLKS; i++) begin
            r = mon_q.pop_front();
            if (i < NUM_INFO_BLKS) exp_d = beat(base, vary, i) & mask;
            else                   exp_d = par[(i - NUM_INFO_BLKS)*MAX_Z +: MAX_Z] & mask;
            checks++;
            if (r.idx !== IDX_W'(i)) begin
                errors++;
                $display("FAIL %s_idx: block %0d got idx %0d, required %0d", tag, i, r.idx, i);
            end
            checks++;
            if (r.d !== exp_d) begin
                errors++;
                $display("FAIL %s_data: block %0d got %h, required %h", tag, i, r.d, exp_d);
            end
            checks++;
            if (r.par !== (i >= NUM_INFO_BLKS)) begin
                errors++;
                $display("FAIL %s_is_par: block %0d got %b, required %b", tag, i, r.par, i >= NUM_INFO_BLKS);
            end
            checks++;
            if (r.last !== (i == TOTAL_BLKS - 1)) begin
                errors++;
                $display("FAIL %s_last: block %0d got %b, required %b", tag, i, r.last, i == TOTAL_BLKS - 1);
            end
            if (chk_lat && i < NUM_INFO_BLKS) begin
                checks++;
                if (r.cyc != acc_cyc[i] + 1) begin
                    errors++;
                    $display("FAIL %s_latency: block %0d out at cycle %0d, required %0d", tag, i, r.cyc, acc_cyc[i] + 1);
                end
            end
        end
    endtask

    task automatic test_reset();
        bus.z_sel = '0; bus.info_valid = 1'b0; bus.info_data = '0;
        bus.par_valid = 1'b0; bus.par_data = '0; bus.cw_ready = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({bus.cw_valid, bus.cw_is_par, bus.cw_last, bus.err_zsel, bus.err_par_ovf, bus.info_ready} !== 6'b0
            || bus.cw_data !== '0 || bus.cw_blk_idx !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid %b data %h idx %0d ready %b, required all zero",
                     bus.cw_valid, bus.cw_data, bus.cw_blk_idx, bus.info_ready);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.info_ready !== 1'b1 || bus.cw_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready: info_ready %b cw_valid %b, required 1 0", bus.info_ready, bus.cw_valid);
        end
    endtask

    task automatic test_z27_basic();
        run_cw(3'b001, ONES, 1'b0, -1, -1, 0, {PAR_W{1'b1}}, '0);
        check_cw("z27", M27, ONES, 1'b0, {PAR_W{1'b1}}, 1'b1);
    endtask

    task automatic test_stall_z81();
        logic [MAX_Z-1:0] base;
        logic [PAR_W-1:0] p;
        int               nstall;
        base = 81'h1_2345_6789_ABCD_EF01_2345;
        p = mk_par(81'h0_F0F0_1234_5678_9ABC_DEF0, 1'b1);
        snap_q.delete();
        snap_en = 1'b1;
        tog_ready = 1'b1;
        run_cw(3'b100, base, 1'b1, -1, -1, 0, p, '0);
        check_cw("z81_stall", M81, base, 1'b1, p, 1'b0);
        tog_ready = 1'b0;
        bus.cw_ready = 1'b1;
        snap_en = 1'b0;
        nstall = 0;
        for (int i = 0; i + 1 < snap_q.size(); i++) begin
            if (snap_q[i].v && !snap_q[i].r) begin
                nstall++;
                checks++;
                if (!snap_q[i+1].v || snap_q[i+1].cyc != snap_q[i].cyc + 1
                    || snap_q[i+1].d !== snap_q[i].d || snap_q[i+1].idx !== snap_q[i].idx) begin
                    errors++;
                    $display("FAIL stall_hold: cycle %0d got idx %0d data %h, required idx %0d data %h",
                             snap_q[i+1].cyc, snap_q[i+1].idx, snap_q[i+1].d, snap_q[i].idx, snap_q[i].d);
                end
            end
        end
        checks++;
        if (nstall == 0) begin
            errors++;
            $display("FAIL stall_seen: got %0d stalled cycles, required > 0", nstall);
        end
    endtask

    task automatic test_par_overflow();
        logic [MAX_Z-1:0] base;
        logic [PAR_W-1:0] p1;
        logic [PAR_W-1:0] p2;
        base = 81'h0_AAAA_5555_CCCC_3333_0F0F;
        p1 = mk_par(81'h1_1111_2222_3333_4444_5555, 1'b1);
        p2 = mk_par(81'h0_9999_8888_7777_6666_5555, 1'b1);
        checks++;
        if (bus.err_par_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_initial: err_par_ovf %b, required 0", bus.err_par_ovf);
        end
        run_cw(3'b010, base, 1'b1, 5, 10, 0, p1, p2);
        check_cw("ovf", M54, base, 1'b1, p1, 1'b0);
        checks++;
        if (bus.err_par_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag: err_par_ovf %b, required 1", bus.err_par_ovf);
        end
    endtask

    task automatic test_zsel_err();
        logic [MAX_Z-1:0] base;
        logic [PAR_W-1:0] p;
        base = 81'h1_FEDC_BA98_7654_3210_FEDC;
        p = mk_par(81'h1_0000_FFFF_0000_FFFF_0000, 1'b1);
        run_cw(3'b011, base, 1'b1, -1, -1, 1, p, '0);
        check_cw("zsel", M81, base, 1'b1, p, 1'b0);
        checks++;
        if (bus.err_zsel !== 1'b1) begin
            errors++;
            $display("FAIL zsel_flag: err_zsel %b, required 1", bus.err_zsel);
        end
    endtask

    task automatic test_reset_mid();
        logic [MAX_Z-1:0] base;
        logic [PAR_W-1:0] p;
        base = 81'h0_1357_9BDF_2468_ACE0_1357;
        p = mk_par(81'h1_3C3C_A5A5_5A5A_C3C3_0000, 1'b1);
        fork
            run_cw(3'b001, ONES, 1'b1, -1, -1, 0, p, '0);
            begin
                int g;
                g = 0;
                while (!(bus.cw_valid && bus.cw_blk_idx == IDX_W'(12)) && g < 200) begin
                    @(negedge CLK);
                    g++;
                end
                checks++;
                if (g >= 200) begin
                    errors++;
                    $display("FAIL rst_mid_wait: idx 12 not seen in %0d cycles, required <200", g);
                end
                abort_cw = 1'b1;
                rst = 1'b1;
                #1;
                checks++;
                if ({bus.cw_valid, bus.cw_is_par, bus.cw_last, bus.info_ready} !== 4'b0
                    || bus.cw_data !== '0 || bus.cw_blk_idx !== '0) begin
                    errors++;
                    $display("FAIL rst_mid_outputs: valid %b data %h idx %0d ready %b, required all zero",
                             bus.cw_valid, bus.cw_data, bus.cw_blk_idx, bus.info_ready);
                end
                checks++;
                if ({bus.err_zsel, bus.err_par_ovf} !== 2'b00) begin
                    errors++;
                    $display("FAIL rst_mid_errs: err_zsel %b err_par_ovf %b, required 0 0",
                             bus.err_zsel, bus.err_par_ovf);
                end
            end
        join
        tick();
        tick();
        rst = 1'b0;
        abort_cw = 1'b0;
        mon_q.delete();
        run_cw(3'b010, base, 1'b1, -1, -1, 0, p, '0);
        check_cw("after_rst", M54, base, 1'b1, p, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [MAX_Z-1:0] b1;
        logic [MAX_Z-1:0] b2;
        logic [PAR_W-1:0] pa;
        logic [PAR_W-1:0] pb;
        int               guard;
        b1 = 81'h1_0246_8ACE_1357_9BDF_0246;
        b2 = 81'h0_FFFF_0000_1234_ABCD_5678;
        pa = mk_par(81'h0_ABCD_EF01_2345_6789_ABCD, 1'b1);
        pb = mk_par(81'h1_5A5A_A5A5_0F0F_F0F0_3C3C, 1'b1);
        mon_q.delete();
        run_cw(3'b001, b1, 1'b1, -1, -1, 3, pa, '0);
        run_cw(3'b100, b2, 1'b1, -1, -1, 0, pb, '0);
        guard = 0;
        while (mon_q.size() < 2*TOTAL_BLKS && guard < 300) begin
            tick();
            guard++;
        end
        checks++;
        if (mon_q.size() < TOTAL_BLKS + 1) begin
            errors++;
            $display("FAIL b2b_count: got %0d blocks, required %0d", mon_q.size(), 2*TOTAL_BLKS);
        end else begin
            checks++;
            if (mon_q[TOTAL_BLKS-1].last !== 1'b1 || mon_q[TOTAL_BLKS].idx !== '0
                || mon_q[TOTAL_BLKS].cyc - mon_q[TOTAL_BLKS-1].cyc > 2) begin
                errors++;
                $display("FAIL b2b_gap: next idx %0d after %0d cycles, required idx 0 within 2",
                         mon_q[TOTAL_BLKS].idx, mon_q[TOTAL_BLKS].cyc - mon_q[TOTAL_BLKS-1].cyc);
            end
        end
        check_cw("b2b_cw1", M27, b1, 1'b1, pa, 1'b0);
        check_cw("b2b_cw2", M81, b2, 1'b1, pb, 1'b0);
    endtask

    initial begin
        test_reset();
        test_z27_basic();
        test_stall_z81();
        test_par_overflow();
        test_zsel_err();
        test_reset_mid();
        test_back_to_back();
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
